regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised successor to the single-cycle CPU register file, for the pipelined core. It provides:
- Configurable width, depth and hardwired-zero register.
- Same-cycle write-to-read bypass.
- Per-register busy scoreboard (issue/writeback/flush) for hazard detection.
- A post-reset clearing sweep, so the data array needs no reset fan-out.

It sits between decode/issue (reads, issue marks) and writeback (write port).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of 2, >= 2
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads see array only
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issues; 0 = register 0 is ordinary
(localparam AW = $clog2(NREGS))

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
ready  out  1  1 when init sweep is complete and the block accepts writes/issues
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_rdata  out  XLEN  read port 1 data, combinational
rs2_rdata  out  XLEN  read port 2 data, combinational
rs1_busy  out  1  read port 1 register has pending producer, combinational
rs2_busy  out  1  read port 2 register has pending producer, combinational
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback register
wr_data  in  XLEN  writeback data
issue_en  in  1  mark issue_rd busy (new in-flight producer)
issue_rd  in  AW  destination being issued
flush  in  1  clear all busy bits (pipeline squash)
busy_cnt  out  AW+1  registered count of busy registers

Behaviour:
- Reset (async, rst=1):
  - State=INIT, sweep index=0.
  - All busy bits=0, busy_cnt=0, ready=0.
  - Data array is not reset.
- INIT state (one register per cycle):
  - Each clock writes 0 to array[idx], then idx++.
  - After writing index NREGS-1, go to RUN on that edge; ready=1 from the next cycle.
  - Sweep takes exactly NREGS cycles after rst deasserts.
  - During INIT: wr_en, issue_en and flush are ignored; rs*_rdata=0, rs*_busy=0.
- rst asserted mid-sweep or mid-RUN: immediate return to INIT; sweep restarts at index 0.
- RUN, write: if wr_en and !(ZERO_REG && wr_addr==0), array[wr_addr]<=wr_data on the edge.
- RUN, read:
  - rs*_rdata = 0 if ZERO_REG && addr==0.
  - Else wr_data if BYPASS && wr_en && wr_addr==addr (write-valid, nonzero per ZERO_REG).
  - Else array[addr].
- Read busy: rs*_busy = busy[addr] && !(wb_hit on that addr), where wb_hit means a valid write to that addr this cycle. The wb_hit term applies only when BYPASS=1; with BYPASS=0, rs*_busy = busy[addr]. Same-cycle issue does not affect rs*_busy.
- Scoreboard next-state, per register r, applied in this order:
  1. Start from busy[r].
  2. Cleared if flush.
  3. Cleared if valid write to r.
  4. Set if issue_en && issue_rd==r && !(ZERO_REG && r==0).
  5. Issue wins over both flush and writeback on the same register (new producer outstanding).
- Write to a non-busy register: data written, busy unchanged (0).
- Duplicate issue to an already-busy register: stays busy, count unchanged.
- busy_cnt: registered popcount of the next-state busy vector; always equals popcount(busy) in the same cycle. Range 0..NREGS, with NREGS reachable only when ZERO_REG=0.

Test Plan:
1. Reset sweep: pre-load garbage via a previous run, pulse rst → ready=0 for exactly 32 cycles after deassert, then 1; all reads return 0; wr_en during INIT to x5=0xDEAD has no effect (x5 reads 0 after ready).
2. Write/read/bypass: BYPASS=1, RUN, wr_en x7=0x12345678 while rs1_addr=7 → rs1_rdata=0x12345678 same cycle; next cycle, wr_en=0 → still 0x12345678. Write x0=0xFFFFFFFF → x0 reads 0.
3. Scoreboard: issue x3 → next cycle rs2_addr=3 gives rs2_busy=1, busy_cnt=1. Writeback x3=0xA5 → rs2_busy=0 in that cycle (bypass), busy_cnt=0 next cycle.
4. Simultaneous: busy x3; same cycle issue x3 + write x3=0x55 → x3 reads 0x55, stays busy, busy_cnt=1. Issue x0 → busy_cnt unchanged.
5. Flush: issue x1, x2, x4 over 3 cycles (busy_cnt=3); flush with issue x9 same cycle → next cycle only x9 busy, busy_cnt=1.
6. Reset mid-sweep: assert rst at sweep index 10 → ready stays 0; a full 32-cycle sweep restarts after deassert; busy_cnt=0 throughout.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register file port bundle: two read ports with busy, writeback, issue/flush, status.
// master = decode/issue/writeback side, slave = the register file.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            ready;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            issue_en;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic [AW:0]     busy_cnt;

    modport master (
        input  ready, rs1_rdata, rs2_rdata, rs1_busy, rs2_busy, busy_cnt,
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd, flush
    );

    modport slave (
        output ready, rs1_rdata, rs2_rdata, rs1_busy, rs2_busy, busy_cnt,
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd, flush
    );
endinterface

// File: rtl/regfile_sb.sv
// Pipelined-core register file with same-cycle write bypass, per-register busy
// scoreboard, and a post-reset zeroing sweep so the data array carries no reset.

// One scoreboard bit: issue (set) dominates flush/writeback (clr).
module regfile_sb_cell (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic busy,
    output logic busy_nxt
);
    assign busy_nxt = set | (busy & ~clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= 1'b0;
        else     busy <= busy_nxt;
    end
endmodule

module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int AW    = $clog2(NREGS);
    localparam int NPORT = 2;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                      state;
    logic [AW-1:0]               sweep_idx;
    logic                        ready_q;
    logic                        run;
    logic                        wr_valid;

    logic [NREGS-1:0][XLEN-1:0]  mem;
    logic [NREGS-1:0]            busy;
    logic [NREGS-1:0]            busy_nxt;
    logic [NREGS-1:0]            set;
    logic [NREGS-1:0]            clr;
    logic [NREGS-1:0]            wr_hit;
    logic [AW:0]                 cnt_nxt;
    logic [AW:0]                 busy_cnt_q;

    logic [NPORT-1:0][AW-1:0]    rs_addr;
    logic [NPORT-1:0][XLEN-1:0]  rs_rdata;
    logic [NPORT-1:0]            rs_busy;

    assign run      = (state == S_RUN);
    assign wr_valid = run && bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    // Sweep FSM: one zero-write per cycle, RUN/ready on the edge writing the last index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            sweep_idx <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == AW'(NREGS - 1)) begin
                        state   <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data array deliberately has no reset; the sweep supplies the zeros.
    always_ff @(posedge clk) begin
        if (!run)          mem[sweep_idx]   <= '0;
        else if (wr_valid) mem[bus.wr_addr] <= bus.wr_data;
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        localparam bit HARD0 = (ZERO_REG != 0) && (r == 0);

        assign wr_hit[r] = wr_valid && (bus.wr_addr == AW'(r));
        assign set[r]    = !HARD0 && run && bus.issue_en && (bus.issue_rd == AW'(r));
        assign clr[r]    = run && (bus.flush || wr_hit[r]);

        regfile_sb_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .set      (set[r]),
            .clr      (clr[r]),
            .busy     (busy[r]),
            .busy_nxt (busy_nxt[r])
        );
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_cnt_q <= '0;
        else     busy_cnt_q <= cnt_nxt;
    end

    assign rs_addr[0] = bus.rs1_addr;
    assign rs_addr[1] = bus.rs2_addr;

    // A write landing this cycle both forwards its data and hides the busy bit it retires.
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic byp;
        always_comb begin
            byp         = 1'b0;
            rs_rdata[p] = '0;
            rs_busy[p]  = 1'b0;
            if (run && !((ZERO_REG != 0) && (rs_addr[p] == '0))) begin
                byp         = (BYPASS != 0) && wr_hit[rs_addr[p]];
                rs_rdata[p] = byp ? bus.wr_data : mem[rs_addr[p]];
                rs_busy[p]  = busy[rs_addr[p]] && !byp;
            end
        end
    end

    assign bus.ready     = ready_q;
    assign bus.rs1_rdata = rs_rdata[0];
    assign bus.rs2_rdata = rs_rdata[1];
    assign bus.rs1_busy  = rs_busy[0];
    assign bus.rs2_busy  = rs_busy[1];
    assign bus.busy_cnt  = busy_cnt_q;
endmodule
